alu_txn_driver: RTL

- Sequential front-end that sits on the master side of the combinational 8-bit ALU datapath and drives it.
- Accepts ALU commands over a valid/ready request channel and drives operand_a/operand_b/opcode from registers.
- Captures y/carry/zero/overflow one cycle later and returns them over a valid/ready response channel.
- Also supports result chaining (previous y as operand_a) and keeps sticky status plus a completed-op counter.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_txn_stats.sv | 30 +++
 rtl/alu_txn_driver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU datapath and its transaction driver.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_DEPTH = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [ALU_DEPTH-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_EQ  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } drv_state_e;

endpackage

// File: rtl/alu_txn_stats.sv
// Sticky carry/overflow bits and saturating completed-op counter; clear beats a coincident hit.
module alu_txn_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hit,
    input  logic             carry,
    input  logic             overflow,
    output logic             sticky_carry,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sticky_carry    <= 1'b0;
            sticky_overflow <= 1'b0;
            count           <= '0;
        end else if (hit) begin
            sticky_carry    <= sticky_carry | carry;
            sticky_overflow <= sticky_overflow | overflow;
            if (count != {CNT_W{1'b1}}) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_txn_driver.sv
// Command/response front-end for the combinational ALU: IDLE waits for a command,
// EXEC lets the registered operands settle through the ALU, RESP holds the captured result.
module alu_txn_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = ALU_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [DEPTH-1:0] cmd_op,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_operand_a,
    output logic [WIDTH-1:0] alu_operand_b,
    output logic [DEPTH-1:0] alu_opcode,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [2:0]       rsp_flags,
    input  logic             clear_stats,
    output logic             sticky_carry,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] op_count
);

    drv_state_e       state_q, state_d;
    logic             load;
    logic             handshake;
    logic [WIDTH-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        load      = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        load    = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers only move on an accepted command, so idle X on cmd_* never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_opcode    <= '0;
        end else if (load) begin
            alu_operand_a <= cmd_chain ? chain_q : cmd_a;
            alu_operand_b <= cmd_b;
            alu_opcode    <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_y     <= '0;
            rsp_flags <= '0;
            chain_q   <= '0;
        end else if (state_q == EXEC) begin
            rsp_y             <= alu_y;
            rsp_flags[FLAG_Z] <= alu_zero;
            rsp_flags[FLAG_C] <= alu_carry;
            rsp_flags[FLAG_V] <= alu_overflow;
            chain_q           <= alu_y;
        end
    end

    assign rsp_valid = (state_q == RESP);

    alu_txn_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear_stats),
        .hit            (handshake),
        .carry          (rsp_flags[FLAG_C]),
        .overflow       (rsp_flags[FLAG_V]),
        .sticky_carry   (sticky_carry),
        .sticky_overflow(sticky_overflow),
        .count          (op_count)
    );

endmodule
